// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request, regfile write and scoreboard bundle
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic                          rf_we_o;
  logic [ADDR_WIDTH-1:0]         rf_rw_o;
  logic [DATA_WIDTH-1:0]         rf_wdata_o;
  logic                          rsv_valid_i;
  logic [ADDR_WIDTH-1:0]         rsv_rd_i;
  logic [2**ADDR_WIDTH-1:0]      busy_o;
  modport slave (
    input  req_valid_i, req_rd_i, req_data_i, rsv_valid_i, rsv_rd_i,
    output req_ready_o, rf_we_o, rf_rw_o, rf_wdata_o, busy_o
  );
  modport master (
    output req_valid_i, req_rd_i, req_data_i, rsv_valid_i, rsv_rd_i,
    input  req_ready_o, rf_we_o, rf_rw_o, rf_wdata_o, busy_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback port sharing with a busy-register scoreboard
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic                clk_i,
  input logic                rstn_i,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0]            ptr_q, ptr_d, gnt_idx, cand;
  logic [NUM_REQ-1:0]       gnt;
  logic                     gnt_any;
  logic [ADDR_WIDTH-1:0]    gnt_rd, rw_q;
  logic [DATA_WIDTH-1:0]    gnt_data, wdata_q;
  logic                     we_q;
  logic [2**ADDR_WIDTH-1:0] busy_q, busy_d;
  // Round-robin pick starting after the last winner, then mux its rd/data and update the scoreboard
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any && bus.req_valid_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_any  = gnt_any && rstn_i;
    gnt      = gnt_any ? NUM_REQ'(1) << gnt_idx : '0;
    ptr_d    = gnt_any ? gnt_idx : ptr_q;
    gnt_rd   = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        gnt_rd   = bus.req_rd_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_data = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    busy_d = busy_q;
    if (gnt_any && gnt_rd != '0) busy_d[gnt_rd] = 1'b0;
    if (bus.rsv_valid_i && bus.rsv_rd_i != '0) busy_d[bus.rsv_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // Pointer, write stage and scoreboard registers; a grant to x0 is acked but never written
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ptr_q   <= PW'(NUM_REQ - 1);
      we_q    <= 1'b0;
      rw_q    <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      we_q   <= gnt_any && gnt_rd != '0;
      if (gnt_any) begin
        rw_q    <= gnt_rd;
        wdata_q <= gnt_data;
      end
    end
  end
  assign bus.req_ready_o = gnt;
  assign bus.rf_we_o     = we_q;
  assign bus.rf_rw_o     = rw_q;
  assign bus.rf_wdata_o  = wdata_q;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks against a behavioural writeback/scoreboard model
module tb_regfile_wb_arbiter;
  logic clk, rstn;
  logic [1:0]  vld;
  logic [4:0]  rd [2];
  logic [31:0] dat [2];
  logic        rsv_v;
  logic [4:0]  rsv_rd;
  logic [1:0]  pend;
  int n_checks, n_fail;
  int last, last_grant;
  logic        exp_we;
  logic [4:0]  exp_rw;
  logic [31:0] exp_wd;
  logic [31:0] busy_m;
  int gseq [4];

  regfile_wb_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  assign bus.req_valid_i = vld;
  assign bus.req_rd_i    = {rd[1], rd[0]};
  assign bus.req_data_i  = {dat[1], dat[0]};
  assign bus.rsv_valid_i = rsv_v;
  assign bus.rsv_rd_i    = rsv_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check the combinational grant, advance the model, check registered outputs.
  task automatic cycle();
    logic [1:0] g;
    int w;
    #1;
    g = '0;
    w = -1;
    if (rstn)
      for (int k = 1; k <= 2; k++)
        if (w < 0 && vld[(last + k) % 2]) w = (last + k) % 2;
    if (w >= 0) g[w] = 1'b1;
    chk("ready", bus.req_ready_o, g);
    @(posedge clk);
    if (!rstn) begin
      exp_we = 0; exp_rw = 0; exp_wd = 0; busy_m = 0; last = 1;
    end else begin
      exp_we = 0;
      if (w >= 0) begin
        exp_we = rd[w] != 0;
        exp_rw = rd[w];
        exp_wd = dat[w];
        last   = w;
        if (rd[w] != 0) busy_m[rd[w]] = 1'b0;
      end
      if (rsv_v && rsv_rd != 0) busy_m[rsv_rd] = 1'b1;
    end
    last_grant = w;
    @(negedge clk);
    chk("we", bus.rf_we_o, exp_we);
    chk("rw", bus.rf_rw_o, exp_rw);
    chk("wdata", bus.rf_wdata_o, exp_wd);
    chk("busy", bus.busy_o, busy_m);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; last = 1; last_grant = -1;
    exp_we = 0; exp_rw = 0; exp_wd = 0; busy_m = 0;
    rstn = 0; vld = 2'b11; rd[0] = 3; rd[1] = 4; dat[0] = 1; dat[1] = 2;
    rsv_v = 1; rsv_rd = 3; pend = 0;
    @(negedge clk);
    cycle();
    cycle();
    chk("t1_busy", bus.busy_o, 0);
    chk("t1_we", bus.rf_we_o, 0);
    rstn = 1; rsv_v = 0;
    vld = 2'b10; rd[1] = 5; dat[1] = 32'hDEADBEEF;
    #1 chk("t2_ready", bus.req_ready_o, 2'b10);
    cycle();
    chk("t2_we", bus.rf_we_o, 1);
    chk("t2_rw", bus.rf_rw_o, 5);
    chk("t2_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
    vld = 2'b11; rd[0] = 10; rd[1] = 11; dat[0] = 32'hA0; dat[1] = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      gseq[i] = last_grant;
      chk("t3_we", bus.rf_we_o, 1);
    end
    for (int i = 0; i < 4; i++) chk("t3_gnt", 64'(gseq[i]), 64'(i % 2));
    vld = 2'b01; rd[0] = 0; dat[0] = 32'h1234;
    #1 chk("t4_ready", bus.req_ready_o, 2'b01);
    cycle();
    chk("t4_we", bus.rf_we_o, 0);
    vld = 2'b00; rsv_v = 1; rsv_rd = 7;
    cycle();
    chk("t5_set", bus.busy_o[7], 1);
    rsv_v = 0; vld = 2'b01; rd[0] = 7; dat[0] = 32'h77;
    cycle();
    chk("t5_clr", bus.busy_o[7], 0);
    rsv_v = 1; rsv_rd = 7;
    cycle();
    chk("t5_setwins", bus.busy_o[7], 1);
    vld = 2'b00; rsv_v = 1; rsv_rd = 0;
    cycle();
    chk("t6_x0", bus.busy_o[0], 0);
    rsv_rd = 9;
    cycle();
    chk("t6_b9", bus.busy_o[9], 1);
    rsv_v = 0; vld = 2'b01; rd[0] = 12; dat[0] = 32'h55; rstn = 0;
    cycle();
    chk("t6_rst_busy", bus.busy_o, 0);
    chk("t6_rst_we", bus.rf_we_o, 0);
    rstn = 1; vld = 0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          rd[i]   = 5'($urandom_range(0, 31));
          dat[i]  = $urandom;
        end
      vld    = pend;
      rsv_v  = $urandom_range(0, 1) == 1;
      rsv_rd = 5'($urandom_range(0, 31));
      rstn   = $urandom_range(0, 49) != 0;
      cycle();
      if (last_grant >= 0) pend[last_grant] = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
